dcache_refill_responder: RTL
============================

Name: dcache_refill_responder

Overview:
- Memory-side responder for the data cache in the MEM stage.
- Serves two request types from the cache controller:
  - line refill (read): returns a 4-word line as a 4-beat burst;
  - line write-back (write): accepts a full 128-bit line in one cycle.
- Models main data memory with a fixed, programmable access latency.
- Line addressing matches the cache tag/index split: line address = byte address [31:4].

Parameters:
- MEM_LINES, 256, number of 16-byte lines held in the backing array; power of two, ≥ 2.
- LATENCY, 4, cycles from request acceptance to first read beat or to write commit; legal range 1..15.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- req_valid, input, 1, cache presents a request.
- req_ready, output, 1, responder idle and able to accept.
- req_write, input, 1, 1 = write-back, 0 = refill.
- req_line_addr, input, 28, line address (byte address [31:4]).
- req_wdata, input, 128, write-back line; word0 in [31:0], word3 in [127:96].
- resp_valid, output, 1, read beat valid.
- resp_data, output, 32, read beat data.
- resp_last, output, 1, marks beat 3.
- resp_ready, input, 1, cache accepts the current beat.
- wr_done, output, 1, one-cycle pulse: write committed.
- resp_err, output, 1, range error flag; see Optional Feature.

Behaviour:
- Reset: at any edge with reset=1, FSM→IDLE and counters cleared.
  - Outputs: req_ready=1 (from first cycle after reset), resp_valid=0, resp_data=0, resp_last=0, wr_done=0, resp_err=0.
  - Backing array is not cleared.
  - A reset mid-burst or mid-wait aborts the transaction; no beats or pulses follow, and an uncommitted write is discarded.
- Acceptance: request accepted at edge E0 where req_valid & req_ready.
  - req_line_addr, req_write and req_wdata are captured at E0.
  - req_ready=1 only in IDLE; one transaction outstanding at a time.
- States:
  - IDLE: accept request → WAIT; latency counter loaded.
  - WAIT: counts LATENCY cycles.
    - Read: → BURST at edge E0+LATENCY.
    - Write: array line written at edge E0+LATENCY, → IDLE.
  - BURST: beat index 0..3.
    - Index advances on each edge with resp_valid & resp_ready.
    - After the beat-3 handshake → IDLE.
- Read timing:
  - resp_valid high starting in the cycle after edge E0+LATENCY.
  - Beats are ordered word0..word3; resp_last=1 only with beat 3.
  - With resp_ready=0, resp_valid, resp_data and resp_last hold stable.
  - resp_data=0 whenever resp_valid=0.
  - With resp_ready held high, read occupancy is LATENCY+4 cycles.
  - req_ready rises the cycle after the final beat handshake.
- Write timing:
  - wr_done=1 for exactly one cycle, the cycle after edge E0+LATENCY.
  - req_ready=1 in that same cycle, so a new request may be accepted at the next edge.
- Address mapping:
  - Array index = req_line_addr mod MEM_LINES.
  - Upper bits are ignored, so addresses wrap (macro off).
- Read-after-write: a refill accepted after wr_done returns the newly written data.
- req_valid while busy is ignored; the cache must hold the request until req_ready.

Optional Feature:
- Macro: DCACHE_RESP_RANGE_CHECK_EN.
- Defined:
  - A request whose req_line_addr ≥ MEM_LINES completes with normal timing.
  - Write: array not modified; wr_done pulses with resp_err=1 in the same cycle.
  - Read: all 4 beats carry resp_data=32'hDEADBEEF with resp_err=1 on each beat.
- Undefined:
  - resp_err is tied 0.
  - Out-of-range addresses wrap modulo MEM_LINES.

Test Plan:
- Reset check: assert reset 3 cycles, release → req_ready=1, resp_valid=0, wr_done=0, resp_data=0 on the first post-reset cycle.
- Write/read round trip (LATENCY=4, resp_ready=1):
  - Write line 28'h5 with 128'h44444444_33333333_22222222_11111111 accepted at E0 → wr_done pulse in the cycle after E0+4.
  - Subsequent read of line 5 → beats 11111111, 22222222, 33333333, 44444444 in consecutive cycles, first beat in the cycle after accept+4; resp_last only on the 4th beat.
- Backpressure: during a read, drop resp_ready for 3 cycles at beat 1 → beat 1 data held constant, no beat skipped or duplicated, 4 total handshakes, req_ready low until after the beat-3 handshake.
- Wrap-around (macro off, MEM_LINES=256): write line 28'h105 with pattern A, then read line 28'h005 → returns pattern A.
- Reset mid-burst: reset asserted after beat 1 handshake → resp_valid=0 next cycle, no further beats; a following read of the same line returns its intact contents.
- Range check (macro on, MEM_LINES=256): read line 28'h100 → 4 beats of DEADBEEF with resp_err=1. Write to 28'h100 → resp_err=1 with wr_done, and line 0 unchanged.

Source files
------------

// File: rtl/dcache_refill_responder.sv
// dcache_refill_responder
//   Memory-side responder for the MEM-stage data cache. Serves 4-beat line refills and
//   single-cycle 128-bit line write-backs from a backing array with a fixed access latency.
//
// Parameters
//   MEM_LINES : number of 16-byte lines in the backing array (power of two, >= 2)
//   LATENCY   : cycles from request acceptance to first read beat / write commit (1..15)
//
// Ports
//   clk, reset                   : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only while idle)
//   req_write                    : 1 = write-back, 0 = refill
//   req_line_addr                : line address (byte address [31:4])
//   req_wdata                    : write-back line, word0 in [31:0]
//   resp_valid/resp_ready        : read beat handshake
//   resp_data, resp_last         : read beat data, marks beat 3
//   wr_done                      : one-cycle pulse when a write commits
//   resp_err                     : out-of-range flag
//
// Build option
//   DCACHE_RESP_RANGE_CHECK_EN : when defined, line addresses >= MEM_LINES are flagged with
//                                resp_err, reads return 32'hDEADBEEF and writes are dropped.
//                                When undefined, addresses wrap modulo MEM_LINES.

module dcache_refill_responder #(
    parameter int unsigned MEM_LINES = 256,
    parameter int unsigned LATENCY   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [27:0]  req_line_addr,
    input  logic [127:0] req_wdata,
    output logic         resp_valid,
    output logic [31:0]  resp_data,
    output logic         resp_last,
    input  logic         resp_ready,
    output logic         wr_done,
    output logic         resp_err
);

    localparam int unsigned IdxW = $clog2(MEM_LINES);

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      beat_q, beat_d;
    logic            wr_done_q, wr_done_d;
    logic [IdxW-1:0] idx_q;
    logic            write_q;
    logic [127:0]    wdata_q;
    logic            err_q;
    logic [127:0]    line_q;
    logic [127:0]    mem [MEM_LINES];

    logic accept;
    logic commit;
    logic mem_we;
    logic req_err;

`ifdef DCACHE_RESP_RANGE_CHECK_EN
    assign req_err = ({4'b0, req_line_addr} >= 32'(MEM_LINES));
`else
    assign req_err = 1'b0;
    // Upper address bits are intentionally dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_line_addr[27:IdxW];
`endif

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid & req_ready;
    // The edge E0+LATENCY: last cycle of WAIT with the counter exhausted.
    assign commit    = (state_q == StWait) && (cnt_q == 4'd0);
    // Gate with reset so a write caught by reset on its commit edge is discarded.
    assign mem_we    = commit & write_q & ~err_q & ~reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        wr_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StWait;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    if (write_q) begin
                        state_d   = StIdle;
                        wr_done_d = 1'b1;
                    end else begin
                        state_d = StBurst;
                        beat_d  = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StBurst: begin
                if (resp_ready) begin
                    if (beat_q == 2'd3) begin
                        state_d = StIdle;
                    end
                    beat_d = beat_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            beat_q    <= 2'd0;
            wr_done_q <= 1'b0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            wr_done_q <= wr_done_d;
            if (accept) begin
                idx_q   <= req_line_addr[IdxW-1:0];
                write_q <= req_write;
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
        end
    end

    // Backing array is not reset; the whole line is latched for the burst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
        if (commit && !write_q) begin
            line_q <= mem[idx_q];
        end
    end

    always_comb begin
        resp_valid = (state_q == StBurst);
        resp_last  = resp_valid && (beat_q == 2'd3);
        resp_data  = 32'd0;
        if (resp_valid) begin
            resp_data = err_q ? 32'hDEADBEEF : line_q[{beat_q, 5'b0} +: 32];
        end
        wr_done = wr_done_q;
`ifdef DCACHE_RESP_RANGE_CHECK_EN
        resp_err = err_q & (resp_valid | wr_done_q);
`else
        resp_err = 1'b0;
`endif
    end

endmodule
